// File: rtl/time_ascii_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_ascii_pkg
// Purpose  : Shared definitions for the time-to-ASCII frame sender.
//            Holds the sequencer state encoding, the ASCII constants, the
//            frame-length constants and the decimal digit-split helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package time_ascii_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // ASCII codes used in the frame
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_QMARK = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  // Frame lengths with and without the CR/LF trailer
  localparam int FRAME_LEN_EOL    = 10;
  localparam int FRAME_LEN_NO_EOL = 8;

  // Largest legal field values
  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // Any digit above 9 is rendered as '?' by the encoder, so an
  // out-of-range field is flagged by forcing its digits to this value.
  localparam logic [3:0] DIGIT_BAD = 4'hF;

  // Decimal split of a 0..63 value; results fit in 4 bits (max tens = 6).
  function automatic logic [3:0] dec_tens(input logic [5:0] value);
    return 4'(value / 6'd10);
  endfunction

  function automatic logic [3:0] dec_ones(input logic [5:0] value);
    return 4'(value % 6'd10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_ascii_enc.sv
`default_nettype none
// ============================================================================
// Module   : digit_ascii_enc
// Purpose  : Combinational encoder from a 4-bit decimal digit to its ASCII
//            character. Digits 0..9 map to '0'..'9'; anything larger maps
//            to '?'.
// Ports    : digit  in  [3:0]  decimal digit
//            ascii  out [7:0]  ASCII character
// Revision : 1.0 - initial release
// ============================================================================
module digit_ascii_enc
  import time_ascii_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASC_QMARK;
    if (digit <= 4'd9) begin
      ascii = ASC_ZERO + {4'h0, digit};
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_ascii_sender.sv
`default_nettype none
// ============================================================================
// Module   : time_ascii_sender
// Purpose  : Latches an hh:mm:ss time on request and streams it to a UART
//            transmitter as an ASCII frame ("hh:mm:ss" plus optional CR/LF),
//            one byte per start/done handshake.
// Ports    : clk         in       system clock
//            reset       in       synchronous active-high reset
//            i_send      in       transmit request, honoured only when idle
//            i_hour      in [4:0] hours   (0..23)
//            i_min       in [5:0] minutes (0..59)
//            i_sec       in [5:0] seconds (0..59)
//            i_tx_done   in       uart_tx byte-finished pulse
//            o_tx_start  out      one-cycle byte start pulse
//            o_tx_data   out[7:0] byte being sent, stable until i_tx_done
//            o_busy      out      frame in progress
//            o_done      out      one-cycle frame-complete pulse
// Revision : 1.0 - initial release
// ============================================================================
module time_ascii_sender
  import time_ascii_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter bit         EOL_EN   = 1'b1
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_send,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_tx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [3:0] LAST_IDX = EOL_EN ? 4'(FRAME_LEN_EOL - 1)
                                           : 4'(FRAME_LEN_NO_EOL - 1);
  localparam int NUM_DIGITS = 6;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_idx;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;

  logic       w_accept;
  logic       w_advance;
  logic       w_hour_ok;
  logic       w_min_ok;
  logic       w_sec_ok;
  logic [3:0] w_digit [NUM_DIGITS];
  logic [7:0] w_char  [NUM_DIGITS];
  logic [7:0] w_byte;

  // Request is only honoured in IDLE; everything else ignores it.
  assign w_accept  = (r_state == IDLE) && i_send;
  // A done pulse counts only while waiting, never in the SEND cycle.
  assign w_advance = (r_state == WAIT) && i_tx_done && (r_idx != LAST_IDX);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    o_tx_start   = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_tx_data    = 8'h00;
    case (r_state)
      IDLE: begin
        if (i_send) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        o_tx_start   = 1'b1;
        o_busy       = 1'b1;
        o_tx_data    = w_byte;
        w_next_state = WAIT;
      end
      WAIT: begin
        o_busy    = 1'b1;
        o_tx_data = w_byte;
        if (i_tx_done) begin
          w_next_state = (r_idx == LAST_IDX) ? DONE : SEND;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Time latch and byte index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= 4'd0;
      r_hour <= 5'd0;
      r_min  <= 6'd0;
      r_sec  <= 6'd0;
    end else begin
      if (w_accept) begin
        r_idx  <= 4'd0;
        r_hour <= i_hour;
        r_min  <= i_min;
        r_sec  <= i_sec;
      end else if (w_advance) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit split on the latched time; an illegal field sends "??"
  // --------------------------------------------------------------------------
  assign w_hour_ok = (r_hour <= HOUR_MAX);
  assign w_min_ok  = (r_min  <= MINSEC_MAX);
  assign w_sec_ok  = (r_sec  <= MINSEC_MAX);

  always_comb begin
    w_digit[0] = w_hour_ok ? dec_tens({1'b0, r_hour}) : DIGIT_BAD;
    w_digit[1] = w_hour_ok ? dec_ones({1'b0, r_hour}) : DIGIT_BAD;
    w_digit[2] = w_min_ok  ? dec_tens(r_min)          : DIGIT_BAD;
    w_digit[3] = w_min_ok  ? dec_ones(r_min)          : DIGIT_BAD;
    w_digit[4] = w_sec_ok  ? dec_tens(r_sec)          : DIGIT_BAD;
    w_digit[5] = w_sec_ok  ? dec_ones(r_sec)          : DIGIT_BAD;
  end

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      digit_ascii_enc u_enc (
        .digit (w_digit[g]),
        .ascii (w_char[g])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame byte mux: HH SEP MM SEP SS [CR LF]
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = w_char[0];
      4'd1:    w_byte = w_char[1];
      4'd2:    w_byte = SEP_CHAR;
      4'd3:    w_byte = w_char[2];
      4'd4:    w_byte = w_char[3];
      4'd5:    w_byte = SEP_CHAR;
      4'd6:    w_byte = w_char[4];
      4'd7:    w_byte = w_char[5];
      4'd8:    w_byte = EOL_EN ? ASC_CR : 8'h00;
      4'd9:    w_byte = EOL_EN ? ASC_LF : 8'h00;
      default: w_byte = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_time_ascii_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_ascii_sender
// Purpose  : Directed self-checking bench for time_ascii_sender. Instance
//            dut_a has the CR/LF trailer, dut_b does not. A small uart
//            model answers each start with a done pulse 3 cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_ascii_sender;

  localparam int UART_DLY = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       send_a, send_b;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic       r_done_a, r_done_b, kick_a;
  logic       tx_done_a;
  logic       start_a, busy_a, done_a, start_b, busy_b, done_b;
  logic [7:0] data_a, data_b;

  assign tx_done_a = r_done_a | kick_a;

  time_ascii_sender #(.SEP_CHAR(8'h3A), .EOL_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .i_send(send_a), .i_hour(hour), .i_min(min),
    .i_sec(sec), .i_tx_done(tx_done_a), .o_tx_start(start_a),
    .o_tx_data(data_a), .o_busy(busy_a), .o_done(done_a)
  );

  time_ascii_sender #(.SEP_CHAR(8'h3A), .EOL_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .i_send(send_b), .i_hour(hour), .i_min(min),
    .i_sec(sec), .i_tx_done(r_done_b), .o_tx_start(start_b),
    .o_tx_data(data_b), .o_busy(busy_b), .o_done(done_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit auto_en = 1'b1;
  int cnt_a, cnt_b;
  int last_txd_cyc_a = 0, last_txd_cyc_b = 0;
  int done_cyc_a = 0, done_cyc_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart model: done pulse UART_DLY cycles after each observed start
  initial begin
    r_done_a = 1'b0; r_done_b = 1'b0; cnt_a = 0; cnt_b = 0;
    forever begin
      @(negedge clk);
      r_done_a = 1'b0;
      r_done_b = 1'b0;
      if (reset) begin
        cnt_a = 0; cnt_b = 0;
      end else begin
        if (cnt_a > 0) begin
          cnt_a--;
          if (cnt_a == 0) begin r_done_a = 1'b1; last_txd_cyc_a = cyc; end
        end else if (auto_en && start_a) cnt_a = UART_DLY;
        if (cnt_b > 0) begin
          cnt_b--;
          if (cnt_b == 0) begin r_done_b = 1'b1; last_txd_cyc_b = cyc; end
        end else if (auto_en && start_b) cnt_b = UART_DLY;
      end
    end
  end

  // byte / done monitor
  initial forever begin
    @(negedge clk);
    if (start_a) q_a.push_back(data_a);
    if (start_b) q_b.push_back(data_b);
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hour = h; min = m; sec = s;
    send_a = 1'b1; send_b = 1'b1;
    tick();
    send_a = 1'b0; send_b = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int i = 0;
    while (q_a.size() < n && i < 500) begin tick(); i++; end
    check_val("byte wait", 32'(q_a.size() >= n), 32'd1);
  endtask

  task automatic run_finish(input string tag, input bit with_b);
    int i = 0;
    while (!done_a && i < 2000) begin tick(); i++; end
    check_val({tag, " done seen"}, done_a, 1'b1);
    check_val({tag, " busy in done"}, busy_a, 1'b0);
    check_val({tag, " done lat"}, done_cyc_a - last_txd_cyc_a, 32'd1);
    if (with_b) check_val({tag, " b done lat"}, done_cyc_b - last_txd_cyc_b, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [79:0] exp);
    check_val({tag, " a len"}, q_a.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      check_val($sformatf("%s a[%0d]", tag, i),
                (i < q_a.size()) ? 32'(q_a[i]) : 32'hFFFF, 32'(exp[79-8*i -: 8]));
    check_val({tag, " b len"}, q_b.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("%s b[%0d]", tag, i),
                (i < q_b.size()) ? 32'(q_b[i]) : 32'hFFFF, 32'(exp[79-8*i -: 8]));
    q_a.delete();
    q_b.delete();
  endtask

  localparam logic [79:0] F_120509 = 80'h31_32_3A_30_35_3A_30_39_0D_0A;
  localparam logic [79:0] F_000000 = 80'h30_30_3A_30_30_3A_30_30_0D_0A;
  localparam logic [79:0] F_235959 = 80'h32_33_3A_35_39_3A_35_39_0D_0A;
  localparam logic [79:0] F_BAD    = 80'h3F_3F_3A_3F_3F_3A_30_37_0D_0A;

  initial begin
    int dc;
    bit stable;
    reset = 1'b1; send_a = 1'b0; send_b = 1'b0; kick_a = 1'b0;
    hour = '0; min = '0; sec = '0;
    repeat (3) tick();
    check_val("rst start", start_a, 1'b0);
    check_val("rst data", data_a, 8'h00);
    check_val("rst busy", busy_a, 1'b0);
    check_val("rst done", done_a, 1'b0);
    check_val("rst b busy", busy_b, 1'b0);
    reset = 1'b0;
    tick();

    // basic frame with start latency
    send_time(5'd12, 6'd5, 6'd9);
    check_val("t1 start lat", start_a, 1'b1);
    check_val("t1 busy lat", busy_a, 1'b1);
    check_val("t1 first byte", data_a, 8'h31);
    run_finish("t1", 1'b1);
    check_frame("t1", F_120509);
    repeat (3) tick();
    check_val("t1 busy after", busy_a, 1'b0);

    // boundaries
    send_time(5'd0, 6'd0, 6'd0);
    run_finish("t2", 1'b1);
    check_frame("t2", F_000000);
    tick();
    send_time(5'd23, 6'd59, 6'd59);
    run_finish("t3", 1'b1);
    check_frame("t3", F_235959);
    // request coinciding with o_done must be dropped
    dc = done_cnt_a;
    send_a = 1'b1;
    tick();
    send_a = 1'b0;
    repeat (10) tick();
    check_val("done-cycle send ignored", q_a.size(), 32'd0);
    check_val("done-cycle busy", busy_a, 1'b0);
    check_val("done-cycle no done", done_cnt_a - dc, 32'd0);

    // out-of-range fields
    send_time(5'd24, 6'd60, 6'd7);
    run_finish("t4", 1'b1);
    check_frame("t4", F_BAD);
    tick();

    // latch / ignore while busy
    send_time(5'd12, 6'd5, 6'd9);
    wait_bytes(3);
    hour = 5'd1; min = 6'd2; sec = 6'd3;
    send_a = 1'b1; send_b = 1'b1;
    tick();
    send_a = 1'b0; send_b = 1'b0;
    run_finish("t5", 1'b1);
    check_frame("t5", F_120509);
    dc = done_cnt_a;
    repeat (20) tick();
    check_val("t5 no second frame", q_a.size(), 32'd0);
    check_val("t5 no extra done", done_cnt_a - dc, 32'd0);

    // withheld done, done during SEND ignored
    auto_en = 1'b0;
    tick();
    send_time(5'd12, 6'd5, 6'd9);
    kick_a = 1'b1;
    tick();
    kick_a = 1'b0;
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (data_a !== 8'h31 || start_a !== 1'b0) stable = 1'b0;
    end
    check_val("t6 data stable", stable, 1'b1);
    check_val("t6 one start", q_a.size(), 32'd1);
    check_val("t6 busy held", busy_a, 1'b1);
    kick_a = 1'b1;
    tick();
    kick_a = 1'b0;
    check_val("t6 next start", start_a, 1'b1);
    check_val("t6 next byte", data_a, 8'h32);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    q_a.delete(); q_b.delete();
    auto_en = 1'b1;

    // spurious done in IDLE
    dc = done_cnt_a;
    kick_a = 1'b1;
    tick();
    kick_a = 1'b0;
    repeat (5) tick();
    check_val("t7 idle no start", q_a.size(), 32'd0);
    check_val("t7 idle busy", busy_a, 1'b0);
    check_val("t7 idle no done", done_cnt_a - dc, 32'd0);

    // reset in WAIT of the fifth byte
    send_time(5'd12, 6'd5, 6'd9);
    wait_bytes(5);
    tick();
    reset = 1'b1;
    tick();
    check_val("t8 rst start", start_a, 1'b0);
    check_val("t8 rst data", data_a, 8'h00);
    check_val("t8 rst busy", busy_a, 1'b0);
    check_val("t8 rst done", done_a, 1'b0);
    reset = 1'b0;
    q_a.delete(); q_b.delete();
    repeat (10) tick();
    check_val("t8 no start after rst", q_a.size(), 32'd0);
    send_time(5'd12, 6'd5, 6'd9);
    check_val("t8 restart byte0", data_a, 8'h31);
    run_finish("t8", 1'b1);
    check_frame("t8", F_120509);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
